ysyx_lsu_dcache: RTL and testbench
==================================

// Module: ysyx_lsu_dcache
// PURPOSE
//  Load/store unit with a parametrised direct-mapped, write-through L1 data cache. Sits between EXU and
//  the bus load/store channels. Adds byte-lane alignment, a store policy (invalidate or update), an
//  uncached MMIO window, a single-cycle flush and misalignment detection. Lines are one DATA_W word.
// PARAMETERS
//  ADDR_W      32           address width
//  DATA_W      32           data width (word = 4 bytes)
//  IDX_W       6            index bits; SETS = 2**IDX_W; tag = addr[ADDR_W-1:IDX_W+2]
//  ST_UPDATE   1            1: store hit merges bytes into line; 0: store hit invalidates line
//  UC_BASE     32'ha0000000 uncached window base (never allocated, always goes to bus)
//  UC_MASK     32'hf0000000 addr is uncached when (addr & UC_MASK) == UC_BASE
// PORTS
//  clk           in   1       clock
//  rst_n         in   1       synchronous active-low reset
//  flush         in   1       invalidate all lines (fence)
//  req_valid     in   1       EXU request
//  req_ready     out  1       high only in IDLE
//  req_wen       in   1       1 store, 0 load
//  req_op        in   4       ysyx_ALU_OP_{LB,LBU,LH,LHU,LW,SB,SH,SW}
//  req_addr      in   ADDR_W  byte address
//  req_wdata     in   DATA_W  store data, right-aligned
//  resp_valid    out  1       one-cycle completion pulse
//  resp_rdata    out  DATA_W  extended load data (0 for stores/errors)
//  resp_err      out  1       misaligned access, valid with resp_valid
//  lsu_araddr_o  out  ADDR_W  load address (req_addr, unmodified)
//  lsu_arvalid_o out  1       held until lsu_rvalid
//  lsu_rstrb_o   out  8       1/3/f for byte/half/word
//  lsu_rdata     in   DATA_W  aligned word containing the address
//  lsu_rvalid    in   1       load data valid
//  lsu_awaddr_o  out  ADDR_W  store address
//  lsu_awvalid_o out  1       held until lsu_wready
//  lsu_wdata_o   out  DATA_W  store data shifted to byte lane addr[1:0]
//  lsu_wstrb_o   out  8       1/3/f shifted left by addr[1:0]
//  lsu_wvalid_o  out  1       equal to lsu_awvalid_o
//  lsu_wready    in   1       store done
// BEHAVIOUR
//  Reset: state IDLE, all valid bits 0, req_ready=1, every other output 0. Reset mid-op aborts bus requests.
//  FSM IDLE/LD/ST/RESP. Accept = req_valid & req_ready; addr/op/wdata/wen registered on accept.
//  - Misaligned (H: addr[0]; W: addr[1:0]!=0): IDLE->RESP, resp_err=1, no bus traffic.
//  - Load hit (cacheable, valid, tag match at accept): IDLE->RESP; resp 1 cycle after accept.
//  - Load miss/uncached: IDLE->LD; arvalid from next cycle until lsu_rvalid; then ->RESP and line
//    fill (cacheable only). The response uses the bus word.
//  - Store: IDLE->ST; aw/wvalid until lsu_wready; ->RESP. On a cacheable hit, when wready is seen:
//    ST_UPDATE=1 merges the strobed bytes; ST_UPDATE=0 clears the valid bit. Misses never allocate.
//  - RESP: resp_valid=1 for exactly 1 cycle, ->IDLE; next accept possible the following cycle.
//  Extraction: byte/half taken from lane addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
//  flush: clears all valid bits in 1 cycle. An in-flight bus transaction is not aborted.
//   The flush beats a same-cycle fill or update, so the line stays invalid.
//   A lookup in the same cycle as flush counts as a miss.
//  lsu_rvalid/lsu_wready outside LD/ST are ignored.
// TESTING
//  LW 0x80000010 miss, rvalid 3 cycles later with 0x11223344 -> resp 0x11223344, arvalid held 3 cycles;
//   repeat LW -> resp 1 cycle after accept, no arvalid.
//  LB 0x80000013 after the fill above -> 0x00000011; LH 0x80000012 -> 0x00001122;
//   with word 0xff80ff80: LB @..10 -> 0xffffff80, LBU -> 0x00000080.
//  SB 0x80000011 data 0xAB (ST_UPDATE=1) -> wstrb 0x02, wdata 0x0000AB00;
//   then LW -> hit, 0x1122AB44. With ST_UPDATE=0 the LW misses instead.
//  LW 0xa0000000 twice -> two bus reads, no hit. LW 0x80000002 -> resp_err=1, no arvalid.
//  flush in the same cycle as rvalid of a fill -> resp correct, the next LW to the same address misses.
//  rst_n=0 while in LD -> next cycle arvalid=0, req_ready=1, previously cached line misses.

Source files
------------

// File: rtl/ysyx_lsu_dcache_if.sv
// EXU request/response and bus load/store channel bundle for the LSU data cache.
interface ysyx_lsu_dcache_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [3:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] lsu_araddr_o;
  logic              lsu_arvalid_o;
  logic [7:0]        lsu_rstrb_o;
  logic [DATA_W-1:0] lsu_rdata;
  logic              lsu_rvalid;
  logic [ADDR_W-1:0] lsu_awaddr_o;
  logic              lsu_awvalid_o;
  logic [DATA_W-1:0] lsu_wdata_o;
  logic [7:0]        lsu_wstrb_o;
  logic              lsu_wvalid_o;
  logic              lsu_wready;

  modport slave (
    input  req_valid, req_wen, req_op, req_addr, req_wdata, lsu_rdata, lsu_rvalid, lsu_wready,
    output req_ready, resp_valid, resp_rdata, resp_err, lsu_araddr_o, lsu_arvalid_o, lsu_rstrb_o,
           lsu_awaddr_o, lsu_awvalid_o, lsu_wdata_o, lsu_wstrb_o, lsu_wvalid_o
  );

  modport master (
    output req_valid, req_wen, req_op, req_addr, req_wdata, lsu_rdata, lsu_rvalid, lsu_wready,
    input  req_ready, resp_valid, resp_rdata, resp_err, lsu_araddr_o, lsu_arvalid_o, lsu_rstrb_o,
           lsu_awaddr_o, lsu_awvalid_o, lsu_wdata_o, lsu_wstrb_o, lsu_wvalid_o
  );
endinterface

// File: rtl/ysyx_lsu_dcache.sv
// Load/store unit with a direct-mapped, write-through, one-word-per-line L1 data cache,
// an uncached MMIO window, single-cycle flush and misalignment detection.
module ysyx_lsu_dcache #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       IDX_W     = 6,
  parameter bit                ST_UPDATE = 1'b1,
  parameter logic [ADDR_W-1:0] UC_BASE   = ADDR_W'(32'ha000_0000),
  parameter logic [ADDR_W-1:0] UC_MASK   = ADDR_W'(32'hf000_0000)
) (
  input logic              clk,
  input logic              rst_n,
  input logic              flush,
  ysyx_lsu_dcache_if.slave bus
);
  localparam int unsigned SETS  = 2 ** IDX_W;
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;
  localparam int unsigned NB    = DATA_W / 8;

  localparam logic [3:0] OP_LB = 4'd0, OP_LBU = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3;
  localparam logic [3:0] OP_SB = 4'd5, OP_SH = 4'd6;

  typedef enum logic [1:0] {S_IDLE, S_LD, S_ST, S_RESP} state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        op_q;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              arvalid_q, arvalid_d;
  logic              awvalid_q, awvalid_d;
  logic [ADDR_W-1:0] araddr_q, awaddr_q;
  logic [7:0]        rstrb_q, wstrb_q;
  logic [DATA_W-1:0] wdata_q;

  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [DATA_W-1:0] data_q [SETS];

  // size code: 0 byte, 1 half, 2 word
  function automatic logic [1:0] size_of(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: size_of = 2'd0;
      OP_LH, OP_LHU, OP_SH: size_of = 2'd1;
      default:              size_of = 2'd2;
    endcase
  endfunction

  function automatic logic [7:0] strb_of(input logic [1:0] sz);
    case (sz)
      2'd0:    strb_of = 8'h01;
      2'd1:    strb_of = 8'h03;
      default: strb_of = 8'h0f;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] mask_of(input logic [1:0] sz);
    case (sz)
      2'd0:    mask_of = DATA_W'(8'hff);
      2'd1:    mask_of = DATA_W'(16'hffff);
      default: mask_of = '1;
    endcase
  endfunction

  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] off);
    misaligned = ((size_of(op) == 2'd1) && off[0]) || ((size_of(op) == 2'd2) && (off != 2'd0));
  endfunction

  function automatic logic cacheable(input logic [ADDR_W-1:0] a);
    cacheable = ((a & UC_MASK) != UC_BASE);
  endfunction

  // pick the addressed lane and extend it according to the load op
  function automatic logic [DATA_W-1:0] extract(input logic [3:0] op, input logic [1:0] off,
                                                input logic [DATA_W-1:0] word);
    logic [DATA_W-1:0] sh;
    sh = word >> {off, 3'b000};
    case (op)
      OP_LB:   extract = {{(DATA_W-8){sh[7]}}, sh[7:0]};
      OP_LBU:  extract = {{(DATA_W-8){1'b0}}, sh[7:0]};
      OP_LH:   extract = {{(DATA_W-16){sh[15]}}, sh[15:0]};
      OP_LHU:  extract = {{(DATA_W-16){1'b0}}, sh[15:0]};
      default: extract = word;
    endcase
  endfunction

  logic              accept_c, req_mis_c, ld_hit_c, cur_hit_c, fill_c, st_hit_c;
  logic [IDX_W-1:0]  req_idx_c, cur_idx_c;
  logic [TAG_W-1:0]  req_tag_c, cur_tag_c;
  logic [DATA_W-1:0] merge_c;

  assign req_idx_c = bus.req_addr[IDX_W+1:2];
  assign req_tag_c = bus.req_addr[ADDR_W-1:IDX_W+2];
  assign cur_idx_c = addr_q[IDX_W+1:2];
  assign cur_tag_c = addr_q[ADDR_W-1:IDX_W+2];
  assign accept_c  = bus.req_valid & req_ready_q;
  assign req_mis_c = misaligned(bus.req_op, bus.req_addr[1:0]);
  // a lookup coinciding with flush must miss
  assign ld_hit_c  = ~flush & cacheable(bus.req_addr) & valid_q[req_idx_c] &
                     (tag_q[req_idx_c] == req_tag_c);
  assign cur_hit_c = cacheable(addr_q) & valid_q[cur_idx_c] & (tag_q[cur_idx_c] == cur_tag_c);
  assign fill_c    = (state_q == S_LD) & bus.lsu_rvalid & cacheable(addr_q);
  assign st_hit_c  = (state_q == S_ST) & bus.lsu_wready & cur_hit_c;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept_c) begin
        if (req_mis_c)        state_d = S_RESP;
        else if (bus.req_wen) state_d = S_ST;
        else if (ld_hit_c)    state_d = S_RESP;
        else                  state_d = S_LD;
      end
      S_LD:   if (bus.lsu_rvalid) state_d = S_RESP;
      S_ST:   if (bus.lsu_wready) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_d  = (state_d == S_IDLE);
    arvalid_d    = (state_d == S_LD);
    awvalid_d    = (state_d == S_ST);
    resp_valid_d = (state_d == S_RESP);
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    if ((state_q == S_IDLE) && accept_c) begin
      resp_err_d = req_mis_c;
      if (!req_mis_c && !bus.req_wen && ld_hit_c)
        resp_rdata_d = extract(bus.req_op, bus.req_addr[1:0], data_q[req_idx_c]);
    end else if ((state_q == S_LD) && bus.lsu_rvalid) begin
      resp_rdata_d = extract(op_q, addr_q[1:0], bus.lsu_rdata);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      arvalid_q    <= 1'b0;
      awvalid_q    <= 1'b0;
      addr_q       <= '0;
      op_q         <= '0;
      araddr_q     <= '0;
      awaddr_q     <= '0;
      rstrb_q      <= '0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
    end else begin
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      arvalid_q    <= arvalid_d;
      awvalid_q    <= awvalid_d;
      if (accept_c) begin
        addr_q <= bus.req_addr;
        op_q   <= bus.req_op;
        if (bus.req_wen) begin
          awaddr_q <= bus.req_addr;
          wstrb_q  <= 8'(strb_of(size_of(bus.req_op)) << bus.req_addr[1:0]);
          wdata_q  <= (bus.req_wdata & mask_of(size_of(bus.req_op))) << {bus.req_addr[1:0], 3'b000};
        end else begin
          araddr_q <= bus.req_addr;
          rstrb_q  <= strb_of(size_of(bus.req_op));
        end
      end
    end
  end

  always_comb begin
    merge_c = data_q[cur_idx_c];
    for (int b = 0; b < NB; b++)
      if (wstrb_q[b]) merge_c[b*8 +: 8] = wdata_q[b*8 +: 8];
  end

  // flush outranks a same-cycle fill or store update
  always_ff @(posedge clk) begin
    if (!rst_n || flush)             valid_q <= '0;
    else if (fill_c)                 valid_q[cur_idx_c] <= 1'b1;
    else if (st_hit_c && !ST_UPDATE) valid_q[cur_idx_c] <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (fill_c) begin
      tag_q[cur_idx_c]  <= cur_tag_c;
      data_q[cur_idx_c] <= bus.lsu_rdata;
    end else if (st_hit_c && ST_UPDATE) begin
      data_q[cur_idx_c] <= merge_c;
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_rdata    = resp_rdata_q;
  assign bus.resp_err      = resp_err_q;
  assign bus.lsu_araddr_o  = araddr_q;
  assign bus.lsu_arvalid_o = arvalid_q;
  assign bus.lsu_rstrb_o   = rstrb_q;
  assign bus.lsu_awaddr_o  = awaddr_q;
  assign bus.lsu_awvalid_o = awvalid_q;
  assign bus.lsu_wdata_o   = wdata_q;
  assign bus.lsu_wstrb_o   = wstrb_q;
  assign bus.lsu_wvalid_o  = awvalid_q;
endmodule

// File: tb/tb_ysyx_lsu_dcache.sv
// Self-checking bench for ysyx_lsu_dcache: vector table plus hand-written flush/reset sequences,
// with a response scoreboard fed at request time and drained on resp_valid.
module tb_ysyx_lsu_dcache;
  localparam logic [3:0] LB = 4'd0, LBU = 4'd1, LH = 4'd2, LHU = 4'd3, LW = 4'd4;
  localparam logic [3:0] SB = 4'd5, SH = 4'd6, SW = 4'd7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  ysyx_lsu_dcache_if bus ();
  ysyx_lsu_dcache dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus_word;
    int          lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [7:0]  exp_wstrb;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.resp_valid) begin
      if (exp_q.size() == 0) chk("spurious_resp", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("r%0d_rdata", e.id), bus.resp_rdata, e.rdata);
        chk($sformatf("r%0d_err", e.id), 32'(bus.resp_err), 32'(e.err));
      end
    end
  end

  function automatic logic [7:0] model_strb(input logic [3:0] op);
    case (op)
      LB, LBU, SB: model_strb = 8'h01;
      LH, LHU, SH: model_strb = 8'h03;
      default:     model_strb = 8'h0f;
    endcase
  endfunction

  // issue one request, act as the bus slave with the given latency, check timing and bus fields
  task automatic run_req(input int id, input vec_t v, input bit fl_req, input bit fl_fill);
    int ar_cnt = 0;
    int aw_cnt = 0;
    int resp_cyc = -1;
    bit is_st = (v.op >= SB);
    @(negedge clk);
    chk($sformatf("r%0d_ready", id), 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = v.op;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.req_wen   = is_st;
    flush         = fl_req;
    exp_q.push_back('{rdata: v.exp_rdata, err: v.exp_err, id: id});
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    flush         = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.lsu_arvalid_o) begin
        ar_cnt++;
        if (ar_cnt == 1) begin
          chk($sformatf("r%0d_araddr", id), bus.lsu_araddr_o, v.addr);
          chk($sformatf("r%0d_rstrb", id), 32'(bus.lsu_rstrb_o), 32'(model_strb(v.op)));
        end
      end
      if (bus.lsu_awvalid_o) begin
        aw_cnt++;
        if (aw_cnt == 1) begin
          chk($sformatf("r%0d_awaddr", id), bus.lsu_awaddr_o, v.addr);
          chk($sformatf("r%0d_wstrb", id), 32'(bus.lsu_wstrb_o), 32'(v.exp_wstrb));
          chk($sformatf("r%0d_wdata", id), bus.lsu_wdata_o, v.exp_wdata);
          chk($sformatf("r%0d_wvalid", id), 32'(bus.lsu_wvalid_o), 32'd1);
        end
      end
      if (bus.resp_valid) begin
        resp_cyc = c;
        break;
      end
      if (v.lat > 0 && (is_st ? aw_cnt : ar_cnt) == v.lat) begin
        if (is_st) bus.lsu_wready = 1'b1;
        else begin
          bus.lsu_rdata  = v.bus_word;
          bus.lsu_rvalid = 1'b1;
        end
        flush = fl_fill;
        @(posedge clk);
        #1;
        bus.lsu_rvalid = 1'b0;
        bus.lsu_wready = 1'b0;
        flush          = 1'b0;
      end
    end
    chk($sformatf("r%0d_latency", id), 32'(resp_cyc), 32'(v.lat + 1));
    chk($sformatf("r%0d_ar_cycles", id), 32'(ar_cnt), 32'(is_st ? 0 : v.lat));
    chk($sformatf("r%0d_aw_cycles", id), 32'(aw_cnt), 32'(is_st ? v.lat : 0));
    @(negedge clk);
    chk($sformatf("r%0d_resp_1cyc", id), 32'(bus.resp_valid), 32'd0);
    chk($sformatf("r%0d_ready_after", id), 32'(bus.req_ready), 32'd1);
  endtask

  vec_t vecs[$];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_wen    = 1'b0;
    bus.req_op     = 4'd0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.lsu_rdata  = '0;
    bus.lsu_rvalid = 1'b0;
    bus.lsu_wready = 1'b0;

    // op, addr, wdata, bus word, latency, rdata, err, wstrb, wdata
    vecs.push_back('{LW,  32'h8000_0010, 32'h0,         32'h1122_3344, 3, 32'h1122_3344, 1'b0, 8'h00, 32'h0});
    vecs.push_back('{LW,  32'h8000_0010, 32'h0,         32'h0,         0, 32'h1122_3344, 1'b0, 8'h00, 32'h0});
    vecs.push_back('{LB,  32'h8000_0013, 32'h0,         32'h0,         0, 32'h0000_0011, 1'b0, 8'h00, 32'h0});
    vecs.push_back('{LH,  32'h8000_0012, 32'h0,         32'h0,         0, 32'h0000_1122, 1'b0, 8'h00, 32'h0});
    vecs.push_back('{LHU, 32'h8000_0010, 32'h0,         32'h0,         0, 32'h0000_3344, 1'b0, 8'h00, 32'h0});
    vecs.push_back('{SB,  32'h8000_0011, 32'h0000_00AB, 32'h0,         2, 32'h0,         1'b0, 8'h02, 32'h0000_AB00});
    vecs.push_back('{LW,  32'h8000_0010, 32'h0,         32'h0,         0, 32'h1122_AB44, 1'b0, 8'h00, 32'h0});
    vecs.push_back('{LW,  32'h8000_0020, 32'h0,         32'hff80_ff80, 1, 32'hff80_ff80, 1'b0, 8'h00, 32'h0});
    vecs.push_back('{LB,  32'h8000_0020, 32'h0,         32'h0,         0, 32'hffff_ff80, 1'b0, 8'h00, 32'h0});
    vecs.push_back('{LBU, 32'h8000_0020, 32'h0,         32'h0,         0, 32'h0000_0080, 1'b0, 8'h00, 32'h0});
    vecs.push_back('{LH,  32'h8000_0022, 32'h0,         32'h0,         0, 32'hffff_ff80, 1'b0, 8'h00, 32'h0});
    vecs.push_back('{LHU, 32'h8000_0022, 32'h0,         32'h0,         0, 32'h0000_ff80, 1'b0, 8'h00, 32'h0});
    vecs.push_back('{SH,  32'h8000_0022, 32'h1234_5678, 32'h0,         1, 32'h0,         1'b0, 8'h0c, 32'h5678_0000});
    vecs.push_back('{LW,  32'h8000_0020, 32'h0,         32'h0,         0, 32'h5678_ff80, 1'b0, 8'h00, 32'h0});
    vecs.push_back('{SB,  32'ha000_0003, 32'h0000_017f, 32'h0,         1, 32'h0,         1'b0, 8'h08, 32'h7f00_0000});
    vecs.push_back('{LW,  32'ha000_0000, 32'h0,         32'hdead_beef, 2, 32'hdead_beef, 1'b0, 8'h00, 32'h0});
    vecs.push_back('{LW,  32'ha000_0000, 32'h0,         32'h1234_5678, 1, 32'h1234_5678, 1'b0, 8'h00, 32'h0});
    vecs.push_back('{LW,  32'h8000_0002, 32'h0,         32'h0,         0, 32'h0,         1'b1, 8'h00, 32'h0});
    vecs.push_back('{SH,  32'h8000_0011, 32'h0000_ffff, 32'h0,         0, 32'h0,         1'b1, 8'h00, 32'h0});
    vecs.push_back('{SW,  32'h8000_0030, 32'hcafe_babe, 32'h0,         1, 32'h0,         1'b0, 8'h0f, 32'hcafe_babe});
    vecs.push_back('{LW,  32'h8000_0030, 32'h0,         32'h0102_0304, 1, 32'h0102_0304, 1'b0, 8'h00, 32'h0});
    vecs.push_back('{LW,  32'h8000_0110, 32'h0,         32'haabb_ccdd, 1, 32'haabb_ccdd, 1'b0, 8'h00, 32'h0});
    vecs.push_back('{LW,  32'h8000_0010, 32'h0,         32'h1122_ab44, 1, 32'h1122_ab44, 1'b0, 8'h00, 32'h0});
    vecs.push_back('{LW,  32'h8000_0010, 32'h0,         32'h0,         0, 32'h1122_ab44, 1'b0, 8'h00, 32'h0});

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_arvalid", 32'(bus.lsu_arvalid_o), 32'd0);
    chk("rst_awvalid", 32'(bus.lsu_awvalid_o | bus.lsu_wvalid_o), 32'd0);
    chk("rst_resp", 32'(bus.resp_valid | bus.resp_err), 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    rst_n = 1'b1;

    // bus handshakes while idle must be ignored
    @(negedge clk);
    bus.lsu_rvalid = 1'b1;
    bus.lsu_wready = 1'b1;
    bus.lsu_rdata  = 32'h5555_5555;
    @(posedge clk);
    #1;
    bus.lsu_rvalid = 1'b0;
    bus.lsu_wready = 1'b0;
    @(negedge clk);
    chk("idle_rvalid_resp", 32'(bus.resp_valid), 32'd0);
    chk("idle_rvalid_ready", 32'(bus.req_ready), 32'd1);

    foreach (vecs[i]) run_req(i, vecs[i], 1'b0, 1'b0);

    // flush together with a lookup that would hit: must miss and refill
    run_req(100, '{LW, 32'h8000_0010, 32'h0, 32'h9988_7766, 1, 32'h9988_7766, 1'b0, 8'h00, 32'h0}, 1'b1, 1'b0);
    run_req(101, '{LW, 32'h8000_0010, 32'h0, 32'h0, 0, 32'h9988_7766, 1'b0, 8'h00, 32'h0}, 1'b0, 1'b0);

    // flush in the fill cycle: response intact, line stays invalid
    run_req(102, '{LW, 32'h8000_0040, 32'h0, 32'h0bad_f00d, 2, 32'h0bad_f00d, 1'b0, 8'h00, 32'h0}, 1'b0, 1'b1);
    run_req(103, '{LW, 32'h8000_0040, 32'h0, 32'h0bad_f00d, 1, 32'h0bad_f00d, 1'b0, 8'h00, 32'h0}, 1'b0, 1'b0);

    // reset during LD aborts the read and drops cached lines
    run_req(104, '{LW, 32'h8000_0050, 32'h0, 32'h55aa_55aa, 1, 32'h55aa_55aa, 1'b0, 8'h00, 32'h0}, 1'b0, 1'b0);
    run_req(105, '{LW, 32'h8000_0050, 32'h0, 32'h0, 0, 32'h55aa_55aa, 1'b0, 8'h00, 32'h0}, 1'b0, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_wen   = 1'b0;
    bus.req_op    = LW;
    bus.req_addr  = 32'h8000_0060;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("abort_arvalid_before", 32'(bus.lsu_arvalid_o), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_arvalid", 32'(bus.lsu_arvalid_o), 32'd0);
    chk("abort_ready", 32'(bus.req_ready), 32'd1);
    chk("abort_resp", 32'(bus.resp_valid), 32'd0);
    rst_n = 1'b1;
    run_req(106, '{LW, 32'h8000_0050, 32'h0, 32'h55aa_55aa, 1, 32'h55aa_55aa, 1'b0, 8'h00, 32'h0}, 1'b0, 1'b0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
